inv_cipher_iter: RTL and testbench
==================================

// Module: inv_cipher_iter
// PURPOSE
//  Iterative AES inverse cipher (FIPS-197 InvCipher): one 128-bit ciphertext block in, plaintext out.
//  Receive-side counterpart of the forward Cipher datapath; applies InvShiftRows/InvSubBytes/
//  AddRoundKey/InvMixColumns, one round per clock. Round keys come from an external key schedule
//  store, read combinationally by index. Valid/ready handshake on both block ports.
// PARAMETERS
//  NR      10  number of rounds (10/12/14 = AES-128/192/256); round-key index width fixed at 4 bits
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  in_valid   in   1    ciphertext block valid
//  in_ready   out  1    core can accept a block
//  in_data    in   128  ciphertext; byte0 = [127:120] = state[0][0]; column-major (byte i -> state[i/4][i%4])
//  rk_idx     out  4    round-key index requested this cycle
//  rk         in   128  round key for rk_idx, same-cycle (combinational) read, same byte order as in_data
//  out_valid  out  1    plaintext block valid
//  out_ready  in   1    downstream accepts plaintext
//  out_data   out  128  plaintext, same byte order
// BEHAVIOUR
//  - Reset (rst_n low, async): fsm=IDLE, round counter=NR, state reg=0; outputs in_ready=1, out_valid=0,
//    out_data=0, rk_idx=NR. Reset mid-operation abandons the block; no output is produced for it.
//  - FSM IDLE -> ROUND -> DONE -> IDLE.
//    IDLE : in_ready=1, rk_idx=NR. On in_valid&in_ready: state <= in_data ^ rk; cnt <= NR-1; -> ROUND.
//    ROUND: in_ready=0, rk_idx=cnt. Each cycle: t = InvSubBytes(InvShiftRows(state)) ^ rk;
//           cnt>0: state <= InvMixColumns(t), cnt <= cnt-1.  cnt==0: state <= t (no InvMixColumns); -> DONE.
//    DONE : out_valid=1, out_data=state, in_ready=0, rk_idx=0. On out_ready: -> IDLE (out_valid drops next cycle).
//  - InvShiftRows: o[c][r] = state[(c - r) mod 4][r]; inverse of forward shiftRows (state[(c+r) mod 4][r]).
//  - InvSubBytes: per-byte inverse S-box lookup, combinational, 16 parallel instances.
//  - InvMixColumns: per column, GF(2^8) mod x^8+x^4+x^3+x+1, matrix rows {0e,0b,0d,09} rotated;
//    xtime chain, all results 8-bit, no carries beyond modular reduction.
//  - Latency: handshake in cycle k -> out_valid first high in cycle k+NR+1. Throughput one block per NR+2
//    cycles minimum (no accept while ROUND/DONE; no overlap of DONE and IDLE accept).
//  - out_data/out_valid held stable while out_valid & !out_ready (AXI-style; no retraction).
//  - in_valid asserted during ROUND/DONE is ignored (in_ready=0); upstream must hold it.
//  - rk must be stable for the whole block; core never latches keys, so key store changes mid-block
//    corrupt that block (caller's responsibility).
//  - cnt wraps never: DONE entered exactly at cnt==0; cnt is reloaded only in IDLE.
// TESTING
//  1 FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c (model schedule on rk), in 3925841d02dc09fbdc118597196a0b32
//    -> out_data 3243f6a8885a308d313198a2e0370734, out_valid first high exactly 11 cycles after accept.
//  2 App.C.1: key 000102..0f, in 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff;
//    check rk_idx sequence 10,9,...,0 over the 11 cycles from accept.
//  3 Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid=1, out_data constant, in_ready=0; then 1 -> IDLE.
//  4 Busy: drive in_valid with a second block during ROUND -> not accepted; accepted in the first IDLE cycle
//    after DONE handshake, both results correct and in order.
//  5 Reset: pull rst_n low at ROUND cnt=5 -> immediately in_ready=1, out_valid=0, rk_idx=10; next block
//    (App.B vector) decrypts correctly.
//  6 Random: 1000 random key/blocks vs software AES model, random in_valid/out_ready gaps -> zero mismatches.

Source files
------------

// File: rtl/inv_cipher_iter.sv
// Iterative AES inverse cipher: one InvCipher round per clock.
// Round keys come from an external schedule store, read combinationally by rk_idx.
module inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [3:0] LAST_KEY = 4'(NR);

  logic [1:0]   fsm;
  logic [3:0]   cnt;
  logic [127:0] st;
  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] t;
  logic [127:0] mixed;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse as x^254 = x^2 * x^4 * ... * x^128, which also maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  // Inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [3:0][7:0] m9;
    logic [3:0][7:0] mb;
    logic [3:0][7:0] md;
    logic [3:0][7:0] me;
    logic [7:0]      a;
    logic [7:0]      x2;
    logic [7:0]      x4;
    logic [7:0]      x8;
    for (int i = 0; i < 4; i++) begin
      a  = col[31-8*i -: 8];
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  always_comb begin
    shifted = '0;
    subbed  = '0;
    mixed   = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        shifted[127-8*(4*c+r) -: 8] = st[127-8*(4*((c-r+4)%4)+r) -: 8];
    for (int i = 0; i < 16; i++)
      subbed[127-8*i -: 8] = inv_sbox(shifted[127-8*i -: 8]);
    t = subbed ^ rk;
    for (int c = 0; c < 4; c++)
      mixed[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
  end

  always_comb begin
    case (fsm)
      IDLE:    rk_idx = LAST_KEY;
      ROUND:   rk_idx = cnt;
      default: rk_idx = 4'd0;
    endcase
  end

  assign in_ready  = (fsm == IDLE);
  assign out_valid = (fsm == DONE);
  assign out_data  = out_valid ? st : '0;

  // The last round skips InvMixColumns; cnt is only reloaded on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= IDLE;
      cnt <= LAST_KEY;
      st  <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            st  <= in_data ^ rk;
            cnt <= LAST_KEY - 4'd1;
            fsm <= ROUND;
          end
        end
        ROUND: begin
          if (cnt == 4'd0) begin
            st  <= t;
            fsm <= DONE;
          end else begin
            st  <= mixed;
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Bench for inv_cipher_iter: FIPS-197 vectors, handshake corner cases, and random
// blocks whose ciphertext comes from a forward AES model with a generated S-box.
module tb_inv_cipher_iter;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  logic [7:0]   sbox [256];
  logic [127:0] rkeys [11];
  logic [127:0] key;
  logic [127:0] pt;
  logic [127:0] ct;
  logic [127:0] pt2;
  logic [127:0] ct2;
  int           vectors = 0;
  int           miscompares = 0;
  int           n;
  bit           done;

  inv_cipher_iter #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assign rk = (rk_idx <= 4'd10) ? rkeys[rk_idx] : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Walk generator 3 and its inverse to fill the forward S-box.
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  task automatic set_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp  = {tmp[23:0], tmp[31:24]};
        tmp  = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rcon, 24'h0};
        rcon = gm(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] p_in);
    logic [7:0]   s [16];
    logic [7:0]   o [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = p_in[127-8*i -: 8] ^ rkeys[0][127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          o[4*c+r] = sbox[s[4*((c+r)%4)+r]];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[4*c]   = gm(o[4*c], 8'h02) ^ gm(o[4*c+1], 8'h03) ^ o[4*c+2] ^ o[4*c+3];
          s[4*c+1] = o[4*c] ^ gm(o[4*c+1], 8'h02) ^ gm(o[4*c+2], 8'h03) ^ o[4*c+3];
          s[4*c+2] = o[4*c] ^ o[4*c+1] ^ gm(o[4*c+2], 8'h02) ^ gm(o[4*c+3], 8'h03);
          s[4*c+3] = gm(o[4*c], 8'h03) ^ o[4*c+1] ^ o[4*c+2] ^ gm(o[4*c+3], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = o[4*c+r];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkeys[rnd][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one block; returns at the first negedge after the accepting edge.
  task automatic applyStimulus(input logic [127:0] blk);
    int w;
    w = 0;
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) checkOutput("accept_timeout", 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_data  = blk;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) checkOutput("out_timeout", 128'(out_valid), 128'd1);
  endtask

  task automatic take_out(input string tag, input logic [127:0] exp);
    out_ready = 1'b1;
    checkOutput(tag, out_data, exp);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    build_sbox();
    for (int r = 0; r < 11; r++) rkeys[r] = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 128'(in_ready), 128'd1);
    checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_out_data", out_data, 128'd0);
    checkOutput("rst_rk_idx", 128'(rk_idx), 128'd10);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] App.B vector and latency");
    set_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    applyStimulus(128'h3925841d02dc09fbdc118597196a0b32);
    wait_out(n);
    checkOutput("appb_latency", 128'(n), 128'd11);
    take_out("appb_data", 128'h3243f6a8885a308d313198a2e0370734);
    checkOutput("appb_back_idle", 128'({in_ready, out_valid}), 128'b10);

    $display("[TB] App.C.1 vector and round-key index sequence");
    set_key(128'h000102030405060708090a0b0c0d0e0f);
    in_valid = 1'b1;
    in_data  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    checkOutput("c1_rk_idx_accept", 128'(rk_idx), 128'd10);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("c1_rk_idx", 128'(rk_idx), 128'(10 - i));
    end
    wait_out(n);
    take_out("c1_data", 128'h00112233445566778899aabbccddeeff);

    $display("[TB] backpressure in DONE");
    applyStimulus(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    wait_out(n);
    for (int i = 0; i < 20; i++) begin
      checkOutput("bp_data", out_data, 128'h00112233445566778899aabbccddeeff);
      checkOutput("bp_flags", 128'({out_valid, in_ready}), 128'b10);
      @(negedge clk);
    end
    take_out("bp_release", 128'h00112233445566778899aabbccddeeff);
    checkOutput("bp_idle", 128'({in_ready, out_valid}), 128'b10);

    $display("[TB] second block held during busy period");
    set_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    ct2 = encrypt(pt2);
    applyStimulus(128'h3925841d02dc09fbdc118597196a0b32);
    in_valid = 1'b1;
    in_data  = ct2;
    checkOutput("busy_in_ready", 128'(in_ready), 128'd0);
    wait_out(n);
    checkOutput("busy_first_latency", 128'(n), 128'd11);
    out_ready = 1'b1;
    checkOutput("busy_first_data", out_data, 128'h3243f6a8885a308d313198a2e0370734);
    @(negedge clk);
    checkOutput("busy_idle_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    wait_out(n);
    checkOutput("busy_second_latency", 128'(n), 128'd11);
    take_out("busy_second_data", pt2);

    $display("[TB] reset in the middle of a block");
    applyStimulus(128'h3925841d02dc09fbdc118597196a0b32);
    n = 0;
    while (rk_idx != 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mid_rk_idx", 128'(rk_idx), 128'd5);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", 128'(in_ready), 128'd1);
    checkOutput("mid_rst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("mid_rst_rk_idx", 128'(rk_idx), 128'd10);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(128'h3925841d02dc09fbdc118597196a0b32);
    wait_out(n);
    checkOutput("post_rst_latency", 128'(n), 128'd11);
    take_out("post_rst_data", 128'h3243f6a8885a308d313198a2e0370734);

    $display("[TB] random keys and blocks");
    for (int b = 0; b < 1000; b++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      set_key(key);
      ct = encrypt(pt);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(ct);
      done = 1'b0;
      for (int w = 0; w < 100 && !done; w++) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          checkOutput("rand_data", out_data, pt);
          done = 1'b1;
        end
        @(negedge clk);
      end
      out_ready = 1'b0;
      if (!done) checkOutput("rand_timeout", 128'(out_valid), 128'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
